// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if;
    logic       req_0, req_1;
    logic [7:0] op_0, op_1;
    logic [7:0] a_0, a_1;
    logic [7:0] b_0, b_1;
    logic       ack_0, ack_1;
    logic       done_0, done_1;
    logic [7:0] res_0, res_1;
    logic       err_0, err_1;
    logic       busy;
    logic [7:0] alu_op, alu_num_1, alu_num_2;
    logic       alu_start;
    logic       alu_clr;
    logic [7:0] alu_result;
    logic       alu_ready;

    modport slave (
        input  req_0, req_1, op_0, op_1, a_0, a_1, b_0, b_1,
        output ack_0, ack_1, done_0, done_1, res_0, res_1, err_0, err_1, busy,
        output alu_op, alu_num_1, alu_num_2, alu_start, alu_clr,
        input  alu_result, alu_ready
    );

    modport master (
        output req_0, req_1, op_0, op_1, a_0, a_1, b_0, b_1,
        input  ack_0, ack_1, done_0, done_1, res_0, res_1, err_0, err_1, busy,
        input  alu_op, alu_num_1, alu_num_2, alu_start, alu_clr,
        output alu_result, alu_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters,
// with a bounded wait for the ALU ready flag and a timeout error path.
module alu_arbiter #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic       ptr_reg, ptr_next;      // last granted requester
    logic       grant_reg, grant_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [1:0] ack_reg, ack_next;
    logic [1:0] done_reg, done_next;
    logic [1:0] err_reg, err_next;
    logic [7:0] res_0_reg, res_0_next;
    logic [7:0] res_1_reg, res_1_next;
    logic [7:0] op_reg, op_next;
    logic [7:0] num_1_reg, num_1_next;
    logic [7:0] num_2_reg, num_2_next;
    logic       start_reg, start_next;
    logic       clr_reg, clr_next;
    logic       busy_reg, busy_next;
    logic       win;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        cnt_next   = cnt_reg;
        ack_next   = 2'b00;
        done_next  = 2'b00;
        err_next   = 2'b00;
        res_0_next = res_0_reg;
        res_1_next = res_1_reg;
        op_next    = op_reg;
        num_1_next = num_1_reg;
        num_2_next = num_2_reg;
        start_next = 1'b0;
        clr_next   = 1'b0;
        // On a tie the requester that was not served last wins.
        win        = (bus.req_0 && bus.req_1) ? ~ptr_reg : bus.req_1;

        case (state_reg)
            IDLE: begin
                if (bus.req_0 || bus.req_1) begin
                    grant_next = win;
                    ack_next   = win ? 2'b10 : 2'b01;
                    op_next    = win ? bus.op_1 : bus.op_0;
                    num_1_next = win ? bus.a_1  : bus.a_0;
                    num_2_next = win ? bus.b_1  : bus.b_0;
                    start_next = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = 8'd0;
                state_next = WAIT;
            end
            WAIT: begin
                // Ready is checked before the timeout so the last WAIT cycle still succeeds.
                if (bus.alu_ready) begin
                    done_next = grant_reg ? 2'b10 : 2'b01;
                    if (grant_reg) res_1_next = bus.alu_result;
                    else           res_0_next = bus.alu_result;
                    state_next = RESP;
                end else if (cnt_reg == LAST_WAIT) begin
                    done_next = grant_reg ? 2'b10 : 2'b01;
                    err_next  = grant_reg ? 2'b10 : 2'b01;
                    if (grant_reg) res_1_next = 8'h00;
                    else           res_0_next = 8'h00;
                    clr_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                ptr_next   = grant_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b1;
            grant_reg <= 1'b0;
            cnt_reg   <= 8'd0;
            ack_reg   <= 2'b00;
            done_reg  <= 2'b00;
            err_reg   <= 2'b00;
            res_0_reg <= 8'h00;
            res_1_reg <= 8'h00;
            op_reg    <= 8'h00;
            num_1_reg <= 8'h00;
            num_2_reg <= 8'h00;
            start_reg <= 1'b0;
            clr_reg   <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            res_0_reg <= res_0_next;
            res_1_reg <= res_1_next;
            op_reg    <= op_next;
            num_1_reg <= num_1_next;
            num_2_reg <= num_2_next;
            start_reg <= start_next;
            clr_reg   <= clr_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.ack_0     = ack_reg[0];
    assign bus.ack_1     = ack_reg[1];
    assign bus.done_0    = done_reg[0];
    assign bus.done_1    = done_reg[1];
    assign bus.err_0     = err_reg[0];
    assign bus.err_1     = err_reg[1];
    assign bus.res_0     = res_0_reg;
    assign bus.res_1     = res_1_reg;
    assign bus.busy      = busy_reg;
    assign bus.alu_op    = op_reg;
    assign bus.alu_num_1 = num_1_reg;
    assign bus.alu_num_2 = num_2_reg;
    assign bus.alu_start = start_reg;
    assign bus.alu_clr   = clr_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU whose
// ready latency is adjustable; a monitor checks every done against the queue.
module tb_alu_arbiter;
    logic clk;
    logic reset;

    alu_arbiter_if bus ();

    alu_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         port;
        logic [7:0] res;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    int         alu_lat   = 1;
    int         cd        = 0;
    logic       model_rdy = 1'b0;
    logic [7:0] model_res = 8'h00;
    logic       spur      = 1'b0;

    assign bus.alu_ready  = model_rdy | spur;
    assign bus.alu_result = model_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ALU stand-in: ready alu_lat cycles after the start strobe, only for add/sub.
    always @(posedge clk) begin
        logic st;
        st = bus.alu_start;
        #1;
        model_rdy = 1'b0;
        if (st) cd = alu_lat;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                case (bus.alu_op)
                    8'h01: begin model_rdy = 1'b1; model_res = bus.alu_num_1 + bus.alu_num_2; end
                    8'h02: begin model_rdy = 1'b1; model_res = bus.alu_num_1 - bus.alu_num_2; end
                    default: ;
                endcase
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (bus.done_0 || bus.done_1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {30'd0, bus.done_1, bus.done_0}, 32'd0);
            end else begin
                e = sb.pop_front();
                p = bus.done_1 ? 1 : 0;
                check("done_port", p, e.port);
                check("done_onehot", bus.done_0 & bus.done_1, 0);
                check("res", p ? bus.res_1 : bus.res_0, e.res);
                check("err", p ? bus.err_1 : bus.err_0, e.err);
                check("alu_clr_with_done", bus.alu_clr, e.err);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_cmd(input int port, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        if (port == 0) begin
            bus.op_0 = op; bus.a_0 = a; bus.b_0 = b; bus.req_0 = 1'b1;
        end else begin
            bus.op_1 = op; bus.a_1 = a; bus.b_1 = b; bus.req_1 = 1'b1;
        end
    endtask

    task automatic wait_ack(input int port, input logic [7:0] r, input logic e, input int lat,
                            input bit push, input bit drop, output int ack_cyc);
        bit seen;
        seen    = 1'b0;
        ack_cyc = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.ack_0 || bus.ack_1) begin
                seen    = 1'b1;
                ack_cyc = cyc;
                check("ack_port", bus.ack_1 ? 1 : 0, port);
                check("start_with_ack", bus.alu_start, 1);
                check("busy_with_ack", bus.busy, 1);
                if (push) sb.push_back('{port, r, e, cyc + lat});
                if (drop) begin
                    if (bus.ack_1) bus.req_1 = 1'b0;
                    else           bus.req_0 = 1'b0;
                end
            end
        end
        if (!seen) check("ack_timeout", 1, 0);
    endtask

    task automatic run(input int port, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic e, input int lat);
        int t;
        int ak;
        t = cyc;
        set_cmd(port, op, a, b);
        wait_ack(port, r, e, lat, 1'b1, 1'b1, ak);
        check("ack_latency", ak, t + 1);
        repeat (lat + 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 10000", cyc);
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3, t, ak;
        reset = 1'b1;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        bus.op_0 = 8'h00; bus.a_0 = 8'h00; bus.b_0 = 8'h00;
        bus.op_1 = 8'h00; bus.a_1 = 8'h00; bus.b_1 = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_alu_clr", bus.alu_clr, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ack", {bus.ack_1, bus.ack_0}, 0);
        check("rst_done", {bus.done_1, bus.done_0}, 0);
        check("rst_start", bus.alu_start, 0);
        check("rst_res_0", bus.res_0, 8'h00);
        check("rst_alu_op", bus.alu_op, 8'h00);

        // Contention: both requesters held from reset release
        set_cmd(0, 8'h01, 8'h01, 8'h02);
        set_cmd(1, 8'h02, 8'h09, 8'h04);
        t = cyc;
        reset = 1'b0;
        wait_ack(0, 8'h03, 1'b0, 2, 1'b1, 1'b0, a0);
        wait_ack(1, 8'h05, 1'b0, 2, 1'b1, 1'b0, a1);
        wait_ack(0, 8'h03, 1'b0, 2, 1'b1, 1'b0, a2);
        wait_ack(1, 8'h05, 1'b0, 2, 1'b1, 1'b0, a3);
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        check("cont_first_ack", a0, t + 1);
        check("cont_space_1", a1 - a0, 4);
        check("cont_space_2", a2 - a1, 4);
        check("cont_space_3", a3 - a2, 4);
        repeat (4) @(negedge clk);

        // Single add, then check requester 1 result is held
        run(0, 8'h01, 8'h05, 8'h03, 8'h08, 1'b0, 2);
        check("res_1_held", bus.res_1, 8'h05);
        check("clr_low_idle", bus.alu_clr, 0);

        // Wrap-around
        run(1, 8'h02, 8'h03, 8'h05, 8'hFE, 1'b0, 2);
        run(0, 8'h01, 8'hC8, 8'h64, 8'h2C, 1'b0, 2);

        // Timeout, ready in the final WAIT cycle, ready one cycle too late
        run(0, 8'h07, 8'h05, 8'h03, 8'h00, 1'b1, 5);
        alu_lat = 4;
        run(1, 8'h01, 8'h11, 8'h22, 8'h33, 1'b0, 5);
        alu_lat = 5;
        run(1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 5);
        alu_lat = 1;
        run(0, 8'h01, 8'h10, 8'h20, 8'h30, 1'b0, 2);

        // Spurious ready while idle
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_idle_busy", bus.busy, 0);
        end
        spur = 1'b0;

        // Spurious ready during RESP and the following IDLE
        set_cmd(0, 8'h01, 8'h01, 8'h01);
        wait_ack(0, 8'h02, 1'b0, 2, 1'b1, 1'b1, ak);
        @(negedge clk);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        check("spur_resp_busy_a", bus.busy, 0);
        @(negedge clk);
        check("spur_resp_busy_b", bus.busy, 0);
        spur = 1'b0;
        @(negedge clk);

        // Reset during WAIT aborts the command; requester 0 then wins a tie
        set_cmd(1, 8'h01, 8'h07, 8'h07);
        wait_ack(1, 8'h00, 1'b0, 2, 1'b0, 1'b1, ak);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_clr", bus.alu_clr, 1);
        check("mid_rst_alu_op", bus.alu_op, 8'h00);
        check("mid_rst_num_1", bus.alu_num_1, 8'h00);
        check("mid_rst_res_0", bus.res_0, 8'h00);
        check("mid_rst_res_1", bus.res_1, 8'h00);
        check("mid_rst_start", bus.alu_start, 0);
        reset = 1'b0;
        t = cyc;
        set_cmd(0, 8'h01, 8'h7F, 8'h01);
        set_cmd(1, 8'h01, 8'h07, 8'h07);
        wait_ack(0, 8'h80, 1'b0, 2, 1'b1, 1'b1, ak);
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        check("tie_after_rst_lat", ak, t + 1);

        repeat (6) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester controller that shares the single 8-bit ALU between command sources, such as the host command decoder and a local sequencer. It arbitrates round-robin, latches the winner's operands, issues a one-cycle start strobe to the ALU, waits for the ALU's ready flag under a timeout, and returns the result or an error to the winning requester. It sits between the command front-end and the ALU and is the only block that drives the ALU's inputs.

## Interface
- TIMEOUT, 4: number of WAIT cycles without alu_ready before a command is failed; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_0, req_1  input  1 each  command request from requester 0 / 1
- op_0, op_1  input  8 each  op code (0x01 add, 0x02 sub; any other value is passed through unchecked)
- a_0, a_1 / b_0, b_1  input  8 each  operand 1 / operand 2
- ack_0, ack_1  output  1 each  one-cycle pulse: command accepted, operands latched
- done_0, done_1  output  1 each  one-cycle pulse: response valid
- res_0, res_1  output  8 each  result; updated only with done, held otherwise
- err_0, err_1  output  1 each  timeout flag; meaningful only while done is high
- busy  output  1  high in every state except IDLE
- alu_op, alu_num_1, alu_num_2  output  8 each  to ALU op_code / num_1 / num_2
- alu_start  output  1  to ALU i_ready
- alu_clr  output  1  to ALU reset
- alu_result  input  8  from ALU result
- alu_ready  input  1  from ALU o_ready

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE
  - If any req is high, grant one requester, latch its op/a/b into alu_op/alu_num_1/alu_num_2, pulse its ack, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration is round-robin via a 1-bit pointer (last granted).
  - When both requests are high, the requester not granted last wins.
  - After reset, requester 0 wins the first tie.
  - A single request always wins.
- ISSUE: alu_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT
  - If alu_ready=1: capture alu_result, clear err, go to RESP.
  - Otherwise increment the counter. When TIMEOUT WAIT cycles have elapsed without alu_ready, set err and go to RESP.
- RESP
  - Pulse done of the granted requester and drive its res/err; res is the captured value, or 0x00 on error.
  - If err: alu_clr=1 for this cycle.
  - Update the pointer, go to IDLE.
- Requests are level-sampled only in IDLE. A requester that still holds req when the FSM returns to IDLE is treated as a new command. Requesters drop req after ack.
- Operands on alu_* stay stable from ack until the FSM leaves RESP.
- alu_ready outside WAIT (late or spurious) is ignored and never produces a done.
- Arithmetic is the ALU's 8-bit wrap-around. The arbiter passes results through unmodified.
- Reset values: state IDLE, pointer favours 0.
  - All ack/done/err/alu_start/busy = 0.
  - res_0, res_1, alu_op, alu_num_1, alu_num_2 = 0x00.
  - alu_clr = 1 while reset is high, 0 after.
- Reset mid-command (any state) aborts the command. No done or err is emitted for it.

## Timing
- Request sampled high in IDLE at cycle T. Then:
  - ack and busy high at T+1 (ISSUE)
  - alu_start high at T+1
  - ALU ready at T+2 (WAIT)
  - done at T+3
  - next request can be sampled at T+4
- Throughput for back-to-back valid commands: one command per 4 cycles.
- Timeout path: WAIT occupies T+2..T+1+TIMEOUT; done with err=1 at T+2+TIMEOUT (T+6 at default).
- alu_ready arriving in the final allowed WAIT cycle counts as success, not timeout.
- ack and done are exactly one cycle wide; never both high in the same cycle for the same requester.

## Test plan
- Single add: req_0 with op 0x01, a 0x05, b 0x03 at T.
  - Expect ack_0 at T+1, alu_start at T+1.
  - Expect done_0 at T+3 with res_0=0x08, err_0=0.
  - res_1/done_1 untouched.
- Wrap-around: req_1 sub 0x02, a 0x03, b 0x05 → res_1=0xFE. Add 0xC8+0x64 → 0x2C.
- Contention: req_0 and req_1 held high continuously from reset release.
  - Grants alternate 0,1,0,1, with ack spacing of 4 cycles.
  - done goes to the matching port each time.
- Timeout: req_0 with op 0x07 (ALU never readies), TIMEOUT=4.
  - Expect done_0 at T+6 with err_0=1, res_0=0x00, and alu_clr high in the same cycle.
  - A following valid command succeeds normally.
- Reset in WAIT: assert reset for one cycle at T+2 of a command.
  - Expect no done, all outputs at reset values.
  - Requester 0 wins the next tie.
- Spurious alu_ready pulsed in IDLE and RESP → no done, no state change.
